// File: rtl/alu_cb_sequencer.sv
// Control sequencer for CB-prefixed BIT/RES/SET ops: steps the ALU through bit-select, operand and result phases.
// Optional (HL) memory operand path enabled by defining ALU_CB_HL_MEM_EN.
module alu_cb_sequencer #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       nreset,
  input  logic       op_valid,
  output logic       op_ready,
  input  logic [7:0] opcode,
  output logic [2:0] reg_rsel,
  input  logic [7:0] reg_rdata,
  output logic       reg_we,
  output logic [2:0] reg_wsel,
  output logic [7:0] reg_wdata,
  output logic [2:0] alu_bs,
  output logic [7:0] alu_op,
  output logic       alu_bs_oe,
  output logic       alu_sh_oe,
  output logic       alu_res_oe,
  output logic       alu_la,
  output logic       alu_lb,
  output logic       alu_r,
  output logic       alu_s,
  output logic       alu_v,
  output logic       alu_ne,
  output logic       alu_ci,
  output logic       alu_l,
  output logic       alu_h,
  input  logic [7:0] alu_result,
  input  logic       alu_zero,
  output logic       flag_we,
  output logic       flag_z,
  output logic       flag_n,
  output logic       flag_h,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic [7:0] mem_wdata,
  input  logic [7:0] mem_rdata,
  input  logic       mem_ack,
  output logic       done,
  output logic       err
);

  typedef enum logic [2:0] {
    S_IDLE, S_MRD, S_LDB, S_LDA, S_RES, S_MWR, S_ERR
  } state_t;

  localparam logic [1:0] GRP_ILL = 2'b00;
  localparam logic [1:0] GRP_BIT = 2'b01;
  localparam logic [1:0] GRP_RES = 2'b10;
  localparam logic [1:0] GRP_SET = 2'b11;
  localparam logic [2:0] REG_HL  = 3'd6;
  localparam int         CW      = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

  state_t        r_state;
  state_t        w_state_next;
  logic [1:0]    r_grp;
  logic [2:0]    r_bit;
  logic [2:0]    r_reg;
  logic [7:0]    r_operand;
  logic [7:0]    r_result;
  logic [CW-1:0] r_wait;
  logic          w_hl_en;
  logic          w_mem_op;
  logic          w_timeout;
  logic          w_fn_en;
  logic          w_mem_rd;
  logic          w_mem_wr;

`ifdef ALU_CB_HL_MEM_EN
  assign w_hl_en = 1'b1;
`else
  assign w_hl_en = 1'b0;
`endif

  assign w_mem_op  = w_hl_en && (r_reg == REG_HL);
  assign w_timeout = (MEM_TIMEOUT != 0) && (int'(r_wait) == MEM_TIMEOUT - 1);
  assign reg_rsel  = r_reg;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_grp     <= '0;
      r_bit     <= '0;
      r_reg     <= '0;
      r_operand <= '0;
      r_result  <= '0;
      r_wait    <= '0;
    end else begin
      if (r_state == S_IDLE && op_valid) begin
        r_grp <= opcode[7:6];
        r_bit <= opcode[5:3];
        r_reg <= opcode[2:0];
      end
      if (r_state == S_LDB && !w_mem_op) begin
        r_operand <= reg_rdata;
      end
      if (r_state == S_MRD && mem_ack) begin
        r_operand <= mem_rdata;
      end
      // Result is only valid while the ALU drives it in RES; hold it for the write-back phase.
      if (r_state == S_RES) begin
        r_result <= alu_result;
      end
      if (w_state_next != r_state) begin
        r_wait <= '0;
      end else if (r_state == S_MRD || r_state == S_MWR) begin
        r_wait <= r_wait + 1'b1;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    op_ready     = 1'b0;
    reg_we       = 1'b0;
    reg_wsel     = '0;
    reg_wdata    = '0;
    alu_bs       = '0;
    alu_op       = '0;
    alu_bs_oe    = 1'b0;
    alu_sh_oe    = 1'b0;
    alu_res_oe   = 1'b0;
    alu_la       = 1'b0;
    alu_lb       = 1'b0;
    alu_ci       = 1'b0;
    alu_l        = 1'b0;
    alu_h        = 1'b0;
    flag_we      = 1'b0;
    flag_z       = 1'b0;
    flag_h       = 1'b0;
    w_mem_rd     = 1'b0;
    w_mem_wr     = 1'b0;
    w_fn_en      = 1'b0;
    done         = 1'b0;
    err          = 1'b0;

    case (r_state)
      S_IDLE: begin
        op_ready = 1'b1;
        if (op_valid) begin
          if (opcode[7:6] == GRP_ILL || (!w_hl_en && opcode[2:0] == REG_HL)) begin
            w_state_next = S_ERR;
          end else if (w_hl_en && opcode[2:0] == REG_HL) begin
            w_state_next = S_MRD;
          end else begin
            w_state_next = S_LDB;
          end
        end
      end
      S_MRD: begin
        w_mem_rd = 1'b1;
        if (mem_ack) begin
          w_state_next = S_LDB;
        end else if (w_timeout) begin
          w_state_next = S_ERR;
        end
      end
      S_LDB: begin
        alu_bs       = r_bit;
        alu_bs_oe    = 1'b1;
        alu_lb       = 1'b1;
        w_state_next = S_LDA;
      end
      S_LDA: begin
        alu_op       = r_operand;
        alu_sh_oe    = 1'b1;
        alu_la       = 1'b1;
        alu_l        = 1'b1;
        alu_ci       = 1'b1;
        w_fn_en      = 1'b1;
        w_state_next = S_RES;
      end
      S_RES: begin
        alu_res_oe = 1'b1;
        alu_h      = 1'b1;
        alu_ci     = 1'b1;
        w_fn_en    = 1'b1;
        if (r_grp == GRP_BIT) begin
          flag_we      = 1'b1;
          flag_z       = alu_zero;
          flag_h       = 1'b1;
          done         = 1'b1;
          w_state_next = S_IDLE;
        end else if (w_mem_op) begin
          w_state_next = S_MWR;
        end else begin
          reg_we       = 1'b1;
          reg_wsel     = r_reg;
          reg_wdata    = alu_result;
          done         = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      S_MWR: begin
        w_mem_wr = 1'b1;
        if (mem_ack) begin
          done         = 1'b1;
          w_state_next = S_IDLE;
        end else if (w_timeout) begin
          w_state_next = S_ERR;
        end
      end
      S_ERR: begin
        err          = 1'b1;
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // BIT/RES are AND-type (RES inverts the mask), SET is OR-type.
  assign alu_r  = w_fn_en && (r_grp == GRP_SET);
  assign alu_s  = w_fn_en && (r_grp != GRP_SET);
  assign alu_ne = w_fn_en && (r_grp == GRP_RES);
  assign alu_v  = 1'b0;
  assign flag_n = 1'b0;

`ifdef ALU_CB_HL_MEM_EN
  assign mem_rd    = w_mem_rd;
  assign mem_wr    = w_mem_wr;
  assign mem_wdata = w_mem_wr ? r_result : 8'h00;
`else
  logic w_unused;
  assign w_unused  = ^{w_mem_rd, w_mem_wr, r_result};
  assign mem_rd    = 1'b0;
  assign mem_wr    = 1'b0;
  assign mem_wdata = 8'h00;
`endif

endmodule
